// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline types: opcode encodings, scoreboard entry layout and
// opcode classification helpers used by the hazard/forwarding logic.
package otter_pipe_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    CSR    = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP_RG3, CSR: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      JALR, LOAD, OP_IMM, CSR, BRANCH, OP_RG3, STORE: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      BRANCH, OP_RG3, STORE: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Forwarding source selection for one operand: picks the youngest in-flight
// producer of the operand, or requests a stall if that producer is an unready load.
module fwd_src_select
  import otter_pipe_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  sb_entry_t [NUM_FWD_STAGES-1:0] entries_i,
  input  logic      [4:0]                addr_i,
  input  logic                           use_i,
  output logic      [SEL_W-1:0]          sel_o,
  output logic                           stall_req_o
);

  logic found;

  always_comb begin
    sel_o       = '0;
    stall_req_o = 1'b0;
    found       = 1'b0;
    // Scan youngest first; the first hit masks every older producer, even when it stalls.
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      if (!found && use_i && (addr_i != 5'd0) &&
          entries_i[k].valid && (entries_i[k].rd == addr_i)) begin
        found = 1'b1;
        if (entries_i[k].is_load && (k < LOAD_LAT)) stall_req_o = 1'b1;
        else                                        sel_o       = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// OTTER hazard/forwarding unit: shift-register scoreboard of in-flight
// destinations, per-operand forward selects, load-use stall and stall counter.
module fwd_scoreboard
  import otter_pipe_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1,
  parameter int CNT_W          = 32,
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ADV,
  input  logic             FLUSH,
  input  logic [6:0]       OPCODE,
  input  logic [4:0]       ADDR_RS1,
  input  logic [4:0]       ADDR_RS2,
  input  logic [4:0]       ADDR_RD,
  output logic [SEL_W-1:0] FWD_RS1,
  output logic [SEL_W-1:0] FWD_RS2,
  output logic             STALL,
  output logic [CNT_W-1:0] STALL_CNT
);

  sb_entry_t [NUM_FWD_STAGES-1:0] entries_q, entries_d;
  logic      [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
  sb_entry_t                      dec_entry;
  logic                           stall_rs1, stall_rs2;

  fwd_src_select #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES),
    .LOAD_LAT      (LOAD_LAT),
    .SEL_W         (SEL_W)
  ) u_sel_rs1 (
    .entries_i  (entries_q),
    .addr_i     (ADDR_RS1),
    .use_i      (uses_rs1(OPCODE)),
    .sel_o      (FWD_RS1),
    .stall_req_o(stall_rs1)
  );

  fwd_src_select #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES),
    .LOAD_LAT      (LOAD_LAT),
    .SEL_W         (SEL_W)
  ) u_sel_rs2 (
    .entries_i  (entries_q),
    .addr_i     (ADDR_RS2),
    .use_i      (uses_rs2(OPCODE)),
    .sel_o      (FWD_RS2),
    .stall_req_o(stall_rs2)
  );

  assign STALL     = stall_rs1 | stall_rs2;
  assign STALL_CNT = stall_cnt_q;

  always_comb begin
    dec_entry.valid   = writes_rd(OPCODE) && (ADDR_RD != 5'd0);
    dec_entry.rd      = ADDR_RD;
    dec_entry.is_load = (OPCODE == LOAD);
    entries_d         = entries_q;
    stall_cnt_d       = stall_cnt_q;
    if (ADV) begin
      // A stalled or flushed decode slot enters the pipe as a bubble.
      entries_d[0] = (STALL || FLUSH) ? '0 : dec_entry;
      for (int k = 1; k < NUM_FWD_STAGES; k++) entries_d[k] = entries_q[k-1];
      if (STALL && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
